// File: rtl/ddr_frame_pkg.sv
// ddr_frame_pkg: shared arbiter states, app command codes and frame geometry
package ddr_frame_pkg;
  typedef enum logic [1:0] {IDLE, WR_BURST, RD_CMD, RD_WAIT} arb_state_t;
  localparam logic [2:0] APP_CMD_WR = 3'd0;
  localparam logic [2:0] APP_CMD_RD = 3'd1;
  localparam int IMG_W = 640;
  localparam int IMG_H = 480;
  localparam int PIX_BITS = 16;
  localparam int APP_DATA_W = 128;
  localparam int FRAME_WORDS_DEF = IMG_W * IMG_H * PIX_BITS / APP_DATA_W;
  localparam int BURST_LEN_DEF = 64;
  localparam int OFFS_W = 17;
endpackage

// File: rtl/ddr_addr_gen.sv
// ddr_addr_gen: per-path word offset counter with frame wrap and banked app address
module ddr_addr_gen
  import ddr_frame_pkg::*;
#(
  parameter int FRAME_WORDS = FRAME_WORDS_DEF,
  parameter int ADDR_W = 28,
  parameter logic [ADDR_W-1:0] BANK_BASE1 = ADDR_W'('h0080000)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_adv,
  input  logic              i_clr,
  input  logic              i_bank,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_wrap
);
  logic [OFFS_W-1:0] r_offset;
  assign o_wrap = i_adv && (r_offset == OFFS_W'(FRAME_WORDS - 1));
  assign o_addr = (i_bank ? BANK_BASE1 : '0) + ADDR_W'({r_offset, 3'b000});
  // offset steps once per accepted word and returns to zero at frame end or on restart
  always_ff @(posedge clk)
    if (!rst_n) r_offset <= '0;
    else r_offset <= (o_wrap || i_clr) ? '0 : r_offset + OFFS_W'(i_adv);
endmodule

// File: rtl/ddr_frame_arbiter.sv
// ddr_frame_arbiter: ping-pong DDR3 frame buffer arbiter between camera writes and UDP reads
module ddr_frame_arbiter
  import ddr_frame_pkg::*;
#(
  parameter int BURST_LEN = BURST_LEN_DEF,
  parameter int FRAME_WORDS = FRAME_WORDS_DEF,
  parameter int ADDR_W = 28,
  parameter logic [ADDR_W-1:0] BANK_BASE1 = ADDR_W'('h0080000),
  parameter int CNT_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_calib_complete,
  input  logic              frame_start,
  input  logic              rd_enable,
  input  logic [CNT_W-1:0]  cam_fifo_cnt,
  input  logic [127:0]      cam_fifo_rd_data,
  output logic              cam_fifo_rd_en,
  input  logic [CNT_W-1:0]  ddr_fifo_space,
  output logic              ddr_fifo_wr_en,
  output logic [127:0]      ddr_fifo_wr_data,
  output logic [ADDR_W-1:0] app_addr,
  output logic [2:0]        app_cmd,
  output logic              app_en,
  input  logic              app_rdy,
  output logic [127:0]      app_wdf_data,
  output logic              app_wdf_wren,
  output logic              app_wdf_end,
  input  logic              app_wdf_rdy,
  input  logic [127:0]      app_rd_data,
  input  logic              app_rd_data_valid,
  output logic              ddr_wr_done,
  output logic              ddr_rd_done,
  output logic              frame_valid
);
  localparam int BC_W = $clog2(BURST_LEN + 1);
  localparam logic [BC_W-1:0] LAST = BC_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] BURST_CNT = CNT_W'(BURST_LEN);
  arb_state_t r_state;
  logic [BC_W-1:0] r_beat, r_ret;
  logic [2:0] r_app_cmd;
  logic r_app_en, r_wdf, r_wr_done, r_rd_done, r_frame_valid;
  logic r_wr_bank, r_rd_bank, r_rd_bank_next, r_restart_pend, r_rd_last;
  logic w_wr_acc, w_rd_acc, w_rd_phase, w_ret_fin, w_restart, w_wr_wrap, w_rd_wrap;
  logic [ADDR_W-1:0] w_wr_addr, w_rd_addr;
  assign w_wr_acc = (r_state == WR_BURST) && app_rdy && app_wdf_rdy;
  assign w_rd_acc = (r_state == RD_CMD) && app_rdy;
  assign w_rd_phase = (r_state == RD_CMD) || (r_state == RD_WAIT);
  assign w_ret_fin = w_rd_phase && app_rd_data_valid && (r_ret == LAST);
  assign w_restart = (r_state == IDLE) && (r_restart_pend || frame_start);
  ddr_addr_gen #(.FRAME_WORDS(FRAME_WORDS), .ADDR_W(ADDR_W), .BANK_BASE1(BANK_BASE1)) u_wr_gen (
    .clk(clk), .rst_n(rst_n), .i_adv(w_wr_acc), .i_clr(w_restart), .i_bank(r_wr_bank),
    .o_addr(w_wr_addr), .o_wrap(w_wr_wrap)
  );
  ddr_addr_gen #(.FRAME_WORDS(FRAME_WORDS), .ADDR_W(ADDR_W), .BANK_BASE1(BANK_BASE1)) u_rd_gen (
    .clk(clk), .rst_n(rst_n), .i_adv(w_rd_acc), .i_clr(1'b0), .i_bank(r_rd_bank),
    .o_addr(w_rd_addr), .o_wrap(w_rd_wrap)
  );
  assign cam_fifo_rd_en = w_wr_acc;
  assign app_wdf_data = (r_state == WR_BURST) ? cam_fifo_rd_data : '0;
  assign ddr_fifo_wr_en = w_rd_phase && app_rd_data_valid;
  assign ddr_fifo_wr_data = w_rd_phase ? app_rd_data : '0;
  assign app_addr = (r_state == RD_CMD) ? w_rd_addr : w_wr_addr;
  assign app_cmd = r_app_cmd;
  assign app_en = r_app_en;
  assign app_wdf_wren = r_wdf;
  assign app_wdf_end = r_wdf;
  assign ddr_wr_done = r_wr_done;
  assign ddr_rd_done = r_rd_done;
  assign frame_valid = r_frame_valid;
  // burst sequencer: writes win arbitration because the camera cannot stall
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_state <= IDLE;
      r_beat <= '0;
      r_ret <= '0;
      r_app_en <= 1'b0;
      r_app_cmd <= APP_CMD_WR;
      r_wdf <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_beat <= '0;
          r_ret <= '0;
          if (init_calib_complete && cam_fifo_cnt >= BURST_CNT) begin
            r_state <= WR_BURST;
            r_app_en <= 1'b1;
            r_app_cmd <= APP_CMD_WR;
            r_wdf <= 1'b1;
          end else if (init_calib_complete && rd_enable && r_frame_valid && ddr_fifo_space >= BURST_CNT) begin
            r_state <= RD_CMD;
            r_app_en <= 1'b1;
            r_app_cmd <= APP_CMD_RD;
          end
        end
        WR_BURST: if (w_wr_acc) begin
          r_beat <= r_beat + BC_W'(1);
          if (r_beat == LAST) begin
            r_state <= IDLE;
            r_app_en <= 1'b0;
            r_wdf <= 1'b0;
          end
        end
        RD_CMD: begin
          r_ret <= r_ret + BC_W'(app_rd_data_valid);
          if (w_rd_acc) begin
            r_beat <= r_beat + BC_W'(1);
            if (r_beat == LAST) begin
              r_state <= RD_WAIT;
              r_app_en <= 1'b0;
              r_app_cmd <= APP_CMD_WR;
            end
          end
        end
        RD_WAIT: begin
          r_ret <= r_ret + BC_W'(app_rd_data_valid);
          if (w_ret_fin) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  // frame bookkeeping: done pulses, bank handoff, valid flag and deferred restart
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_wr_done <= 1'b0;
      r_rd_done <= 1'b0;
      r_frame_valid <= 1'b0;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_rd_bank_next <= 1'b0;
      r_restart_pend <= 1'b0;
      r_rd_last <= 1'b0;
    end else begin
      r_wr_done <= w_wr_wrap;
      r_rd_done <= w_ret_fin && (r_rd_last || w_rd_wrap);
      r_rd_last <= w_rd_wrap || (r_rd_last && !w_ret_fin);
      if (w_wr_wrap) begin
        r_frame_valid <= 1'b1;
        r_wr_bank <= ~r_wr_bank;
        r_rd_bank_next <= r_wr_bank;
      end
      if (w_rd_wrap) r_rd_bank <= r_rd_bank_next;
      r_restart_pend <= !w_restart && (r_restart_pend || frame_start);
    end
endmodule

// File: tb/tb_ddr_frame_arbiter.sv
// tb_ddr_frame_arbiter: directed phases with randomized ready/return timing against a transaction model
module tb_ddr_frame_arbiter;
  localparam int BL = 64;
  localparam int FW = 128;
  localparam int AW = 28;
  localparam int CW = 10;
  localparam logic [AW-1:0] B1 = 28'h0080000;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, init_calib_complete, frame_start, rd_enable;
  logic [CW-1:0] cam_fifo_cnt, ddr_fifo_space;
  logic [127:0] cam_fifo_rd_data, ddr_fifo_wr_data, app_wdf_data, app_rd_data;
  logic cam_fifo_rd_en, ddr_fifo_wr_en, app_en, app_rdy, app_wdf_wren, app_wdf_end, app_wdf_rdy;
  logic app_rd_data_valid, ddr_wr_done, ddr_rd_done, frame_valid;
  logic [AW-1:0] app_addr;
  logic [2:0] app_cmd;
  ddr_frame_arbiter #(.BURST_LEN(BL), .FRAME_WORDS(FW), .ADDR_W(AW), .BANK_BASE1(B1), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .init_calib_complete(init_calib_complete), .frame_start(frame_start),
    .rd_enable(rd_enable), .cam_fifo_cnt(cam_fifo_cnt), .cam_fifo_rd_data(cam_fifo_rd_data),
    .cam_fifo_rd_en(cam_fifo_rd_en), .ddr_fifo_space(ddr_fifo_space), .ddr_fifo_wr_en(ddr_fifo_wr_en),
    .ddr_fifo_wr_data(ddr_fifo_wr_data), .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en),
    .app_rdy(app_rdy), .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .app_wdf_rdy(app_wdf_rdy), .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .ddr_wr_done(ddr_wr_done), .ddr_rd_done(ddr_rd_done), .frame_valid(frame_valid)
  );
  int checks = 0, errors = 0;
  int m_wr_off = 0, m_rd_off = 0, m_beats = 0, n_wr = 0, n_cmd = 0, n_ret = 0, cam_avail = 0, rdy_mode = 0;
  bit m_wr_bank = 0, m_rd_bank = 0, m_rd_next = 0, m_valid = 0, m_pend = 0;
  bit exp_wr_done = 0, exp_rd_done = 0, popped = 0;
  logic [31:0] cam_seq = 32'h1000;
  logic [127:0] ret_q[$];
  logic [128:0] exp_q[$];

  function automatic logic [127:0] mem(logic [AW-1:0] a);
    return {4{4'hD, a}};
  endfunction

  function automatic logic [AW-1:0] base(bit b, int off);
    return (b ? B1 : AW'(0)) + AW'(off * 8);
  endfunction

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // transaction-level model of frame offsets, banks and pending restart
  task automatic observe();
    logic [AW-1:0] a;
    logic [128:0] e;
    bit last;
    chk("wr_done", ddr_wr_done, exp_wr_done);
    chk("rd_done", ddr_rd_done, exp_rd_done);
    chk("frame_valid", frame_valid, m_valid);
    chk("fifo_wr_en", ddr_fifo_wr_en, app_rd_data_valid);
    exp_wr_done = 0;
    exp_rd_done = 0;
    popped = cam_fifo_rd_en;
    if (cam_fifo_rd_en) begin
      chk("wr_rdy", app_rdy && app_wdf_rdy, 1);
      chk("wr_ctrl", {app_en, app_wdf_wren, app_wdf_end, app_cmd}, {3'b111, 3'd0});
      if (m_beats % BL == 0 && m_pend) begin
        m_wr_off = 0;
        m_pend = 0;
      end
      chk("wr_addr", app_addr, base(m_wr_bank, m_wr_off));
      chk("wr_data", app_wdf_data, {4{cam_seq}});
      m_wr_off++;
      m_beats++;
      n_wr++;
      if (m_wr_off == FW) begin
        m_wr_off = 0;
        exp_wr_done = 1;
        m_rd_next = m_wr_bank;
        m_wr_bank = !m_wr_bank;
        m_valid = 1;
      end
    end
    if (app_en && app_cmd == 3'd1 && app_rdy) begin
      a = base(m_rd_bank, m_rd_off);
      chk("rd_addr", app_addr, a);
      m_rd_off++;
      n_cmd++;
      last = 0;
      if (m_rd_off == FW) begin
        m_rd_off = 0;
        m_rd_bank = m_rd_next;
        last = 1;
      end
      ret_q.push_back(mem(a));
      exp_q.push_back({last, mem(a)});
    end
    if (ddr_fifo_wr_en) begin
      chk("rd_ret_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rd_data", ddr_fifo_wr_data, e[127:0]);
        exp_rd_done = e[128];
        n_ret++;
      end
    end
    if (frame_start) m_pend = 1;
  endtask

  task automatic drive();
    if (popped) begin
      cam_avail--;
      cam_seq++;
      popped = 0;
    end
    cam_fifo_cnt = CW'(cam_avail);
    cam_fifo_rd_data = {4{cam_seq}};
    app_rd_data_valid = 0;
    if (ret_q.size() > 0 && $urandom_range(0, 3) != 0) begin
      app_rd_data_valid = 1;
      app_rd_data = ret_q.pop_front();
    end
    if (rdy_mode == 0) {app_rdy, app_wdf_rdy} = 2'b11;
    else if (rdy_mode == 1) {app_rdy, app_wdf_rdy} = 2'($urandom);
    else begin
      app_rdy = !app_rdy;
      app_wdf_rdy = 1;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic add_cam(int n);
    cam_avail += n;
    cam_fifo_cnt = CW'(cam_avail);
  endtask

  task automatic run_until_wr(int target);
    int n = 0;
    while (n_wr < target && n < 3000) begin
      tick();
      n++;
    end
    chk("wr_progress", n_wr, target);
  endtask

  task automatic read_burst(int mode);
    int n = 0;
    int start = n_cmd;
    rdy_mode = mode;
    rd_enable = 1;
    ddr_fifo_space = CW'(BL);
    while (n_cmd == start && n < 1000) begin
      tick();
      n++;
    end
    rd_enable = 0;
    while ((n_ret < start + BL || app_en) && n < 3000) begin
      tick();
      n++;
    end
    repeat (3) tick();
    chk("rd_cmd_count", n_cmd - start, BL);
    chk("rd_ret_count", n_ret - start, BL);
  endtask

  initial begin
    bit seen;
    rst_n = 0;
    init_calib_complete = 0;
    frame_start = 0;
    rd_enable = 0;
    ddr_fifo_space = '0;
    cam_fifo_cnt = '0;
    cam_fifo_rd_data = {4{cam_seq}};
    app_rdy = 1;
    app_wdf_rdy = 1;
    app_rd_data = '0;
    app_rd_data_valid = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctrl", {app_en, app_wdf_wren, app_wdf_end, cam_fifo_rd_en, ddr_fifo_wr_en,
                     ddr_wr_done, ddr_rd_done, frame_valid, app_cmd}, 0);
    chk("rst_addr", app_addr, 0);
    rst_n = 1;
    add_cam(BL);
    repeat (10) begin
      tick();
      chk("calib_gate_en", app_en, 0);
    end
    chk("calib_gate_pop", n_wr, 0);
    init_calib_complete = 1;
    run_until_wr(BL);
    repeat (6) tick();
    chk("single_burst_pops", n_wr, BL);
    chk("single_burst_idle", app_en, 0);
    rdy_mode = 1;
    add_cam(BL);
    run_until_wr(2 * BL);
    repeat (4) tick();
    chk("frame0_valid", frame_valid, 1);
    rdy_mode = 0;
    add_cam(BL);
    run_until_wr(150);
    frame_start = 1;
    tick();
    frame_start = 0;
    run_until_wr(3 * BL);
    add_cam(BL);
    run_until_wr(4 * BL);
    add_cam(BL);
    run_until_wr(5 * BL);
    repeat (4) tick();
    read_burst(2);
    read_burst(1);
    read_burst(2);
    rdy_mode = 0;
    add_cam(BL);
    rd_enable = 1;
    ddr_fifo_space = CW'(BL);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (app_en) begin
        seen = 1;
        chk("prio_first_cmd", app_cmd, 0);
      end
    end
    chk("prio_seen", seen, 1);
    read_burst(0);
    chk("prio_write_done", n_wr, 6 * BL);
    for (int k = 0; k < 4; k++) begin
      int fs = $urandom_range(1, 120);
      int i = 0;
      rdy_mode = 1;
      add_cam(BL);
      while (n_wr < (7 + k) * BL && i < 3000) begin
        tick();
        frame_start = (i == fs);
        i++;
      end
      frame_start = 0;
      chk("tail_wr", n_wr, (7 + k) * BL);
      if ($urandom_range(0, 1) == 1) read_burst(1);
    end
    repeat (6) tick();
    chk("ret_drain", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
